// File: rtl/cv32e40p_pkg.sv
// Shared tile-loader constants and the loader FSM state encoding.
package cv32e40p_pkg;

    localparam int unsigned TILE_DIM   = 4;
    localparam int unsigned TILE_WORDS = TILE_DIM * TILE_DIM;
    localparam int unsigned TILE_IDX_W = $clog2(TILE_WORDS);
    localparam int unsigned TILE_POS_W = $clog2(TILE_DIM);

    typedef enum logic [1:0] {
        TL_IDLE,
        TL_FETCH,
        TL_DRAIN,
        TL_PRESENT
    } tile_ld_state_e;

endpackage

// File: rtl/cv32e40p_tile_addr_gen.sv
// Walks a TILE_DIM x TILE_DIM tile in row-major order with a running byte pointer,
// stepping by one word per column and by the row pitch on a column wrap.
module cv32e40p_tile_addr_gen
    import cv32e40p_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] pitch_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0]     WORD_BYTES = ADDR_W'(4);
    localparam logic [ADDR_W-1:0]     COL_SPAN   = ADDR_W'((TILE_DIM - 1) * 4);
    localparam logic [ADDR_W-1:0]     ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [TILE_POS_W-1:0] POS_LAST   = TILE_POS_W'(TILE_DIM - 1);

    logic [TILE_POS_W-1:0] row_q, row_d;
    logic [TILE_POS_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0]     ptr_q, ptr_d;
    logic [ADDR_W-1:0]     pitch_q, pitch_d;

    always_comb begin
        row_d   = row_q;
        col_d   = col_q;
        ptr_d   = ptr_q;
        pitch_d = pitch_q;
        if (load_i) begin
            row_d   = '0;
            col_d   = '0;
            ptr_d   = base_i;
            pitch_d = pitch_i;
        end else if (advance_i) begin
            if (col_q == POS_LAST) begin
                // Jump back to column 0 of the next row without a multiplier.
                col_d = '0;
                row_d = row_q + TILE_POS_W'(1);
                ptr_d = ptr_q + pitch_q - COL_SPAN;
            end else begin
                col_d = col_q + TILE_POS_W'(1);
                ptr_d = ptr_q + WORD_BYTES;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q   <= '0;
            col_q   <= '0;
            ptr_q   <= '0;
            pitch_q <= '0;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            ptr_q   <= ptr_d;
            pitch_q <= pitch_d;
        end
    end

    assign addr_o = ptr_q & ALIGN_MASK;
    assign last_o = (row_q == POS_LAST) && (col_q == POS_LAST);

endmodule

// File: rtl/cv32e40p_tile_loader.sv
// Fetches one TILE_DIM x TILE_DIM tile over an OBI-style read port with up to
// MAX_OUT requests in flight, then presents it flattened on a valid/ready port.
module cv32e40p_tile_loader
    import cv32e40p_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic [ADDR_W-1:0]            base_addr_i,
    input  logic [ADDR_W-1:0]            row_pitch_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         data_req_o,
    output logic [ADDR_W-1:0]            data_addr_o,
    input  logic                         data_gnt_i,
    input  logic                         data_rvalid_i,
    input  logic [DATA_W-1:0]            data_rdata_i,
    output logic                         tile_valid_o,
    input  logic                         tile_ready_i,
    output logic [TILE_WORDS*DATA_W-1:0] tile_data_o
);

    localparam logic [1:0]            MAX_OUT_L = 2'(MAX_OUT);
    localparam logic [TILE_IDX_W-1:0] RSP_LAST  = TILE_IDX_W'(TILE_WORDS - 1);

    tile_ld_state_e        state_q;
    logic                  busy_q;
    logic                  req_q;
    logic                  tile_valid_q;
    logic [1:0]            out_q, out_d;
    logic [TILE_IDX_W-1:0] rsp_cnt_q;
    logic [DATA_W-1:0]     buf_q [TILE_WORDS];

    logic gnt_acc, rsp_acc, rsp_last, addr_load, addr_last;

    assign addr_load = (state_q == TL_IDLE) && start_i;
    assign gnt_acc   = req_q && data_gnt_i;
    // Stray or pre-reset responses are dropped: only counted while something is in flight.
    assign rsp_acc   = data_rvalid_i && (out_q != 2'd0)
                       && ((state_q == TL_FETCH) || (state_q == TL_DRAIN));
    assign rsp_last  = (rsp_cnt_q == RSP_LAST);

    always_comb begin
        out_d = out_q;
        if (gnt_acc) out_d = out_d + 2'd1;
        if (rsp_acc) out_d = out_d - 2'd1;
    end

    cv32e40p_tile_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load_i    (addr_load),
        .base_i    (base_addr_i),
        .pitch_i   (row_pitch_i),
        .advance_i (gnt_acc),
        .addr_o    (data_addr_o),
        .last_o    (addr_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= TL_IDLE;
            busy_q       <= 1'b0;
            req_q        <= 1'b0;
            tile_valid_q <= 1'b0;
            out_q        <= '0;
            rsp_cnt_q    <= '0;
            for (int unsigned k = 0; k < TILE_WORDS; k++) buf_q[k] <= '0;
        end else begin
            out_q <= out_d;
            if (rsp_acc) begin
                buf_q[rsp_cnt_q] <= data_rdata_i;
                rsp_cnt_q        <= rsp_cnt_q + TILE_IDX_W'(1);
            end
            unique case (state_q)
                TL_IDLE: begin
                    if (start_i) begin
                        state_q   <= TL_FETCH;
                        busy_q    <= 1'b1;
                        req_q     <= 1'b1;
                        out_q     <= '0;
                        rsp_cnt_q <= '0;
                    end
                end
                TL_FETCH: begin
                    // req only drops on a grant, so an ungranted request stays put.
                    if (gnt_acc && addr_last) begin
                        state_q <= TL_DRAIN;
                        req_q   <= 1'b0;
                    end else begin
                        req_q <= (out_d < MAX_OUT_L);
                    end
                end
                TL_DRAIN: begin
                    if (rsp_acc && rsp_last) begin
                        state_q      <= TL_PRESENT;
                        tile_valid_q <= 1'b1;
                    end
                end
                TL_PRESENT: begin
                    if (tile_ready_i) begin
                        state_q      <= TL_IDLE;
                        tile_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                end
                default: state_q <= TL_IDLE;
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign data_req_o   = req_q;
    assign tile_valid_o = tile_valid_q;
    assign done_o       = tile_valid_q && tile_ready_i;

    for (genvar k = 0; k < TILE_WORDS; k++) begin : g_flat
        assign tile_data_o[k*DATA_W +: DATA_W] = buf_q[k];
    end

endmodule

// File: tb/tb_cv32e40p_tile_loader.sv
// Scoreboard bench for the tile loader: MAX_OUT=2 DUT with a stallable memory
// model, plus a MAX_OUT=1 DUT on a zero-wait memory.
module tb_cv32e40p_tile_loader;
    import cv32e40p_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned TW = TILE_WORDS * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start, start1;
    logic [AW-1:0] base, pitch, base1, pitch1;
    logic          busy, done, req, busy1, done1, req1;
    logic [AW-1:0] addr, addr1;
    logic          gnt, rvalid, gnt1, rvalid1;
    logic [DW-1:0] rdata, rdata1;
    logic          tvalid, ready, tvalid1, ready1;
    logic [TW-1:0] tdata, tdata1;

    cv32e40p_tile_loader #(.DATA_W(DW), .ADDR_W(AW), .MAX_OUT(2)) u_dut (
        .clk(clk), .rst(rst), .start_i(start), .base_addr_i(base), .row_pitch_i(pitch),
        .busy_o(busy), .done_o(done), .data_req_o(req), .data_addr_o(addr),
        .data_gnt_i(gnt), .data_rvalid_i(rvalid), .data_rdata_i(rdata),
        .tile_valid_o(tvalid), .tile_ready_i(ready), .tile_data_o(tdata)
    );

    cv32e40p_tile_loader #(.DATA_W(DW), .ADDR_W(AW), .MAX_OUT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .base_addr_i(base1), .row_pitch_i(pitch1),
        .busy_o(busy1), .done_o(done1), .data_req_o(req1), .data_addr_o(addr1),
        .data_gnt_i(gnt1), .data_rvalid_i(rvalid1), .data_rdata_i(rdata1),
        .tile_valid_o(tvalid1), .tile_ready_i(ready1), .tile_data_o(tdata1)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Hand-computed request addresses: base 0x1000 pitch 0x40, and the wrapping case.
    logic [AW-1:0] tab_a [16] = '{32'h00001000, 32'h00001004, 32'h00001008, 32'h0000100C,
                                  32'h00001040, 32'h00001044, 32'h00001048, 32'h0000104C,
                                  32'h00001080, 32'h00001084, 32'h00001088, 32'h0000108C,
                                  32'h000010C0, 32'h000010C4, 32'h000010C8, 32'h000010CC};
    logic [AW-1:0] tab_w [16] = '{32'hFFFFFFF0, 32'hFFFFFFF4, 32'hFFFFFFF8, 32'hFFFFFFFC,
                                  32'h00000000, 32'h00000004, 32'h00000008, 32'h0000000C,
                                  32'h00000010, 32'h00000014, 32'h00000018, 32'h0000001C,
                                  32'h00000020, 32'h00000024, 32'h00000028, 32'h0000002C};

    logic [AW-1:0] exp_addr_q [$];
    logic [TW-1:0] exp_tile_q [$];

    task automatic check(input string name, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Memory returns its own address as data, so a tile is just its address list.
    function automatic logic [TW-1:0] build_tile(input int sel);
        logic [TW-1:0] t;
        t = '0;
        for (int k = 0; k < 16; k++) t[k*DW +: DW] = (sel != 0) ? tab_w[k] : tab_a[k];
        return t;
    endfunction

    task automatic issue(input int sel, input bit with_tile);
        for (int k = 0; k < 16; k++) exp_addr_q.push_back((sel != 0) ? tab_w[k] : tab_a[k]);
        if (with_tile) exp_tile_q.push_back(build_tile(sel));
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model for the MAX_OUT=2 DUT: optional grant stalls and in-order delayed responses.
    logic          stall_mode = 1'b0;
    logic [AW-1:0] rsp_data_q [$];
    int            rsp_time_q [$];
    int            last_ready = 0;
    initial begin
        int t;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rsp_data_q.size() > 0 && rsp_time_q[0] <= cyc) begin
                rvalid = 1'b1;
                rdata  = rsp_data_q.pop_front();
                void'(rsp_time_q.pop_front());
            end else begin
                rvalid = 1'b0;
                rdata  = '0;
            end
            gnt = req && (!stall_mode || ($urandom_range(0, 9) >= 3));
            if (req && gnt) begin
                t = cyc + 1 + (stall_mode ? int'($urandom_range(0, 3)) : 0);
                if (t <= last_ready) t = last_ready + 1;
                last_ready = t;
                rsp_data_q.push_back(addr);
                rsp_time_q.push_back(t);
            end
        end
    end

    // Scoreboard monitor for the MAX_OUT=2 DUT.
    int            gcnt = 0;
    int            mout = 0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr  = '0;
    initial forever begin
        @(negedge clk);
        if (req && gnt) mout++;
        if (rvalid && mout > 0) mout--;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("req_addr_hold", {req, addr}, {1'b1, prev_addr});
            if (req && gnt) begin
                gcnt++;
                if (exp_addr_q.size() == 0) check("unexpected_grant", 1'b1, 1'b0);
                else check("req_addr", addr, exp_addr_q.pop_front());
            end
            prev_stall = req && !gnt;
            prev_addr  = addr;
            if (tvalid && ready) begin
                if (exp_tile_q.size() == 0) check("unexpected_tile", 1'b1, 1'b0);
                else check("tile_data", tdata, exp_tile_q.pop_front());
                check("done_handshake", done, 1'b1);
            end else begin
                check("done_no_handshake", done, 1'b0);
            end
            if (busy) check("outstanding_le_2", (mout <= 2), 1'b1);
        end
    end

    // Zero-wait memory and pending-response check for the MAX_OUT=1 DUT.
    logic          g1_neg = 1'b0;
    logic [AW-1:0] a1_neg = '0;
    int            out1   = 0;
    initial begin
        gnt1 = 1'b0; rvalid1 = 1'b0; rdata1 = '0;
        forever begin
            @(posedge clk);
            #2;
            rvalid1 = g1_neg;
            rdata1  = a1_neg;
            gnt1    = req1;
        end
    end
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (req1) check("req1_while_pending", out1, 0);
            if (rvalid1 && out1 > 0) out1--;
            if (req1 && gnt1) out1++;
        end
        g1_neg = req1 && gnt1;
        a1_neg = addr1;
    end

    task automatic wait_tvalid(input int maxc, output int seen);
        seen = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (tvalid) begin
                seen = cyc;
                break;
            end
        end
        if (seen < 0) check("tile_valid_timeout", 1'b0, 1'b1);
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] p, output int t0);
        @(posedge clk);
        #1;
        base = b; pitch = p; start = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, seen, g0;
        rst = 1'b1; start = 1'b0; base = '0; pitch = '0; ready = 1'b0;
        start1 = 1'b0; base1 = '0; pitch1 = '0; ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_req", req, 1'b0);
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_addr", addr, '0);
        check("rst_tdata", tdata, '0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;

        // Zero-wait fetch on both DUTs; ready already high before the tile is valid.
        issue(0, 1'b1);
        ready = 1'b1;
        @(posedge clk);
        #1;
        base = 32'h1000; pitch = 32'h40; start = 1'b1;
        base1 = 32'h1000; pitch1 = 32'h40; start1 = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0; start1 = 1'b0;
        wait_tvalid(40, seen);
        check("latency_max_out2", seen - t0, 18);
        check("tile_word5", tdata[5*DW +: DW], 32'h00001044);
        @(negedge clk);
        check("idle_after_done", {busy, tvalid}, 2'b00);
        seen = -1;
        for (int i = 0; i < 60 && seen < 0; i++) begin
            if (tvalid1) seen = cyc;
            else @(negedge clk);
        end
        check("latency_max_out1", seen - t0, 33);
        check("tile1_data", tdata1, build_tile(0));
        check("done1_handshake", done1, 1'b1);

        // Random grant stalls and response delays; tile must match the zero-wait one.
        stall_mode = 1'b1;
        issue(0, 1'b1);
        pulse_start(32'h1000, 32'h40, t0);
        wait_tvalid(300, seen);
        repeat (2) @(negedge clk);
        stall_mode = 1'b0;

        // Consumer back-pressure while presenting; a start during PRESENT is ignored.
        ready = 1'b0;
        issue(0, 1'b1);
        pulse_start(32'h1000, 32'h40, t0);
        wait_tvalid(40, seen);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            start = (i == 1);
            @(negedge clk);
            check("hold_tvalid", tvalid, 1'b1);
            check("hold_tdata", tdata, build_tile(0));
        end
        @(posedge clk);
        #1;
        start = 1'b0; ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("start_ignored", {busy, req, tvalid}, 3'b000);
        end

        // Reset after the 7th grant, then drop the late responses and refetch.
        issue(0, 1'b0);
        g0 = gcnt;
        pulse_start(32'h1000, 32'h40, t0);
        for (int i = 0; i < 40 && (gcnt - g0) < 7; i++) @(negedge clk);
        check("seven_grants", gcnt - g0, 7);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_outputs", {busy, done, req, tvalid}, 4'b0000);
        check("midrst_addr", addr, '0);
        check("midrst_tdata", tdata, '0);
        exp_addr_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10 && rsp_data_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        check("late_rvalid_drain", rsp_data_q.size(), 0);
        check("late_rvalid_ignored", {busy, tvalid}, 2'b00);
        check("late_rvalid_tdata", tdata, '0);
        issue(0, 1'b1);
        pulse_start(32'h1000, 32'h40, t0);
        wait_tvalid(40, seen);
        check("latency_after_reset", seen - t0, 18);

        // Address wrap modulo 2^32.
        issue(1, 1'b1);
        pulse_start(32'hFFFFFFF0, 32'h10, t0);
        wait_tvalid(40, seen);
        check("latency_wrap", seen - t0, 18);
        repeat (3) @(negedge clk);
        check("addr_queue_empty", exp_addr_q.size(), 0);
        check("tile_queue_empty", exp_tile_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
